regfile_dump: RTL and testbench

Readback sequencer for the register file: the read-side counterpart to the switch-driven write path that loads addresses, mode, write data and PC frame by frame.
- On a start pulse it walks R0..R15, then the PC, under a fixed register mode.
- Each captured word goes to the seven-segment display path through a valid/ready handshake.
- It advances on a step pulse (manual) or after a hold timer expires (auto).

---
 rtl/regfile_dump_pkg.sv | 23 ++
 rtl/regfile_dump_if.sv | 28 ++
 rtl/regfile_dump_dwell_timer.sv | 34 +++
 rtl/regfile_dump.sv | 137 +++++++++++++
 tb/tb_regfile_dump.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared types and constants for the register file readback path
package regfile_dump_pkg;

    // Register file bus widths. The register file and the display use these same defaults.
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;
    localparam int RF_MODE_W = 5;

    // Blank pattern: every digit shows '8'.
    localparam logic [31:0] BLANK_WORD = 32'h8888_8888;
    // Index of the PC entry. It comes after R0..R15.
    localparam logic [4:0]  PC_IDX     = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DWELL,
        ST_DONE
    } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - register file read port plus display valid/ready stream
// master: dump sequencer (drives R_Addr, M_out, out_data, out_valid)
// slave : register file + display sink (drives R_Data, R_Data_PC, out_ready)
interface regfile_dump_if
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int MODE_W = RF_MODE_W
);
    logic [ADDR_W-1:0] R_Addr;
    logic [MODE_W-1:0] M_out;
    logic [DATA_W-1:0] R_Data;
    logic [DATA_W-1:0] R_Data_PC;
    logic [DATA_W:0]   out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output R_Addr, M_out, out_data, out_valid,
        input  R_Data, R_Data_PC, out_ready
    );

    modport slave (
        input  R_Addr, M_out, out_data, out_valid,
        output R_Data, R_Data_PC, out_ready
    );
endinterface

// File: rtl/regfile_dump_dwell_timer.sv
// rtl/regfile_dump_dwell_timer.sv - auto-advance dwell down-counter
// Ports: clk, Rst_n (async active-low), load (reload to HOLD_CYCLES-1),
//        en (decrement, saturates at zero), expired (count is zero).
module dwell_timer #(
    parameter int HOLD_CYCLES = 50000000
)(
    input  logic clk,
    input  logic Rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    // At least one bit wide, so the counter still exists when HOLD_CYCLES == 1.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign expired = (count_q == '0);
endmodule

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks R0..R15 then PC and streams each word to the display
// Ports: clk, Rst_n (async active-low), start/step pulses, auto_mode, M_in (mode latched at start),
//        bus (register file read port + out_data/out_valid/out_ready stream),
//        idx (0-15 = Rn, 16 = PC), busy, done.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W      = RF_DATA_W,
    parameter int ADDR_W      = RF_ADDR_W,
    parameter int MODE_W      = RF_MODE_W,
    parameter int HOLD_CYCLES = 50000000
)(
    input  logic              clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              auto_mode,
    input  logic [MODE_W-1:0] M_in,
    regfile_dump_if.master    bus,
    output logic [4:0]        idx,
    output logic              busy,
    output logic              done
);
    localparam logic [DATA_W-1:0] BLANK = DATA_W'(BLANK_WORD);

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [MODE_W-1:0] m_out_q, m_out_d;
    logic [DATA_W:0]   out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic       timer_load, timer_en, timer_expired;
    logic       advance;
    logic [4:0] idx_nxt;

    dwell_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_dwell_timer (
        .clk     (clk),
        .Rst_n   (Rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign idx_nxt = idx_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        r_addr_d    = r_addr_q;
        m_out_d     = m_out_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_ADDR;
                    m_out_d  = M_in;
                    idx_d    = 5'd0;
                    r_addr_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            // The address is already on R_Addr here. This cycle lets the combinational read settle.
            ST_ADDR: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                out_data_d  = {((idx_q == PC_IDX) ? bus.R_Data_PC : bus.R_Data), 1'b1};
                out_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    timer_load  = 1'b1;
                    state_d     = ST_DWELL;
                end
            end
            ST_DWELL: begin
                // In manual mode the timer keeps its value, so a later switch back to auto resumes from it.
                timer_en = auto_mode;
                advance  = auto_mode ? timer_expired : step;
                if (advance) begin
                    if (idx_q == PC_IDX) begin
                        state_d    = ST_DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        out_data_d = {BLANK, 1'b0};
                    end else begin
                        state_d  = ST_ADDR;
                        idx_d    = idx_nxt;
                        r_addr_d = (idx_nxt == PC_IDX) ? '0 : idx_nxt[ADDR_W-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            r_addr_q    <= '0;
            m_out_q     <= '0;
            out_data_q  <= {BLANK, 1'b0};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            r_addr_q    <= r_addr_d;
            m_out_q     <= m_out_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.R_Addr    = r_addr_q;
    assign bus.M_out     = m_out_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign idx           = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump
module tb_regfile_dump;
    localparam int HOLD = 4;
    localparam logic [32:0] BLANK_OUT = {32'h8888_8888, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       auto_mode = 1'b0;
    logic [4:0] m_in = 5'd0;
    logic       ready = 1'b1;
    logic [4:0] idx;
    logic       busy, done;

    logic [31:0] rf [16];
    logic [31:0] pc_val;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    regfile_dump_if bus ();

    assign bus.R_Data    = rf[bus.R_Addr];
    assign bus.R_Data_PC = pc_val;
    assign bus.out_ready = ready;

    regfile_dump #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .Rst_n     (rst_n),
        .start     (start),
        .step      (step),
        .auto_mode (auto_mode),
        .M_in      (m_in),
        .bus       (bus),
        .idx       (idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int i);
        return (i < 16) ? rf[i] : pc_val;
    endfunction

    task automatic fill_random;
        for (int n = 0; n < 16; n++) rf[n] = $urandom;
        pc_val = $urandom;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int w = 0;
        while (!bus.out_valid && w < 60) begin
            tick;
            w++;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid_timeout: out_valid=%b required 1", tag, bus.out_valid);
        end
    endtask

    // Checks one presented word, completes its transfer, and optionally steps past it.
    task automatic dump_word(input int i, input bit do_step);
        wait_valid($sformatf("word%0d", i));
        n_checks++;
        if (bus.out_data !== {exp_word(i), 1'b1}) begin
            n_fail++;
            $display("FAIL word%0d_data: got %h required %h", i, bus.out_data, {exp_word(i), 1'b1});
        end
        n_checks++;
        if (idx !== 5'(i)) begin
            n_fail++;
            $display("FAIL word%0d_idx: got %0d required %0d", i, idx, i);
        end
        ready = 1'b1;
        tick;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL word%0d_valid_drop: got %b required 0", i, bus.out_valid);
        end
        if (do_step) begin
            step = 1'b1;
            tick;
            step = 1'b0;
        end
    endtask

    task automatic check_done(input string tag, input logic [4:0] m_exp);
        int w = 0;
        while (!done && w < 20) begin
            tick;
            w++;
        end
        n_checks++;
        if ({done, busy, bus.out_valid, bus.out_data} !== {3'b100, BLANK_OUT}) begin
            n_fail++;
            $display("FAIL %s_done: done=%b busy=%b valid=%b data=%h required 1 0 0 %h",
                     tag, done, busy, bus.out_valid, bus.out_data, BLANK_OUT);
        end
        n_checks++;
        if (bus.M_out !== m_exp) begin
            n_fail++;
            $display("FAIL %s_mode: got %b required %b", tag, bus.M_out, m_exp);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({bus.out_valid, busy, done, idx, bus.R_Addr, bus.M_out, bus.out_data} !==
            {3'b000, 5'd0, 4'd0, 5'd0, BLANK_OUT}) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b busy=%b done=%b idx=%0d addr=%0d m=%b data=%h",
                     bus.out_valid, busy, done, idx, bus.R_Addr, bus.M_out, bus.out_data);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            n_checks++;
            if ({bus.out_valid, busy, done, bus.out_data} !== {3'b000, BLANK_OUT}) begin
                n_fail++;
                $display("FAIL idle_stable c%0d: valid=%b busy=%b done=%b data=%h required 0 0 0 %h",
                         c, bus.out_valid, busy, done, bus.out_data, BLANK_OUT);
            end
        end
    endtask

    task automatic test_manual_dump;
        int lat;
        for (int n = 0; n < 16; n++) rf[n] = 32'h1000_0000 + n;
        pc_val = 32'hDEAD_BEEF;
        m_in = 5'b10000;
        auto_mode = 1'b0;
        ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick;
            lat++;
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL start_latency: got %0d cycles required 3", lat);
        end
        n_checks++;
        if ({busy, bus.M_out} !== {1'b1, 5'b10000}) begin
            n_fail++;
            $display("FAIL manual_start: busy=%b m=%b required 1 10000", busy, bus.M_out);
        end
        for (int i = 0; i <= 16; i++) dump_word(i, 1'b1);
        check_done("manual", 5'b10000);
    endtask

    task automatic test_backpressure;
        logic [32:0] held;
        int extra;
        pulse_start;
        for (int i = 0; i < 5; i++) dump_word(i, 1'b1);
        ready = 1'b0;
        wait_valid("bp");
        held = bus.out_data;
        for (int c = 0; c < 10; c++) begin
            tick;
            n_checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, 32'h1000_0005, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_stall c%0d: valid=%b data=%h required 1 %h",
                         c, bus.out_valid, bus.out_data, {32'h1000_0005, 1'b1});
            end
        end
        ready = 1'b1;
        tick;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) extra++;
            tick;
        end
        n_checks++;
        if (extra != 0 || idx !== 5'd5 || bus.out_data !== held) begin
            n_fail++;
            $display("FAIL bp_single_transfer: extra_valid=%0d idx=%0d data=%h required 0 5 %h",
                     extra, idx, bus.out_data, held);
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        for (int i = 6; i <= 16; i++) dump_word(i, 1'b1);
        check_done("bp", 5'b10000);
    endtask

    task automatic test_auto_mode;
        int prev, t, gap_exp;
        fill_random;
        m_in = 5'($urandom);
        auto_mode = 1'b1;
        ready = 1'b1;
        pulse_start;
        prev = 0;
        for (int i = 0; i <= 16; i++) begin
            wait_valid($sformatf("auto%0d", i));
            t = cyc;
            n_checks++;
            if (bus.out_data !== {exp_word(i), 1'b1}) begin
                n_fail++;
                $display("FAIL auto%0d_data: got %h required %h", i, bus.out_data, {exp_word(i), 1'b1});
            end
            if (i > 0) begin
                // Words arrive HOLD+3 cycles apart. Dropping to manual for 5 cycles adds 5.
                gap_exp = (i == 4) ? HOLD + 3 + 5 : HOLD + 3;
                n_checks++;
                if (t - prev != gap_exp) begin
                    n_fail++;
                    $display("FAIL auto%0d_gap: got %0d required %0d", i, t - prev, gap_exp);
                end
            end
            prev = t;
            tick;
            if (i == 3) begin
                auto_mode = 1'b0;
                repeat (5) tick;
                auto_mode = 1'b1;
            end
        end
        check_done("auto", m_in);
        auto_mode = 1'b0;
    endtask

    task automatic test_ignored_inputs;
        logic [4:0] m_a;
        int stray;
        fill_random;
        m_a = 5'($urandom);
        m_in = m_a;
        ready = 1'b1;
        pulse_start;
        for (int i = 0; i < 7; i++) dump_word(i, 1'b1);
        ready = 1'b0;
        wait_valid("ign");
        pulse_start;
        m_in = ~m_a;
        step = 1'b1;
        tick;
        step = 1'b0;
        n_checks++;
        if ({bus.out_valid, idx, busy, bus.M_out} !== {1'b1, 5'd7, 1'b1, m_a}) begin
            n_fail++;
            $display("FAIL ign_present: valid=%b idx=%0d busy=%b m=%b required 1 7 1 %b",
                     bus.out_valid, idx, busy, bus.M_out, m_a);
        end
        dump_word(7, 1'b0);
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (bus.out_valid || idx !== 5'd7) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL ign_step_not_queued: got %0d advancing cycles required 0", stray);
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        for (int i = 8; i <= 16; i++) dump_word(i, 1'b1);
        check_done("ign", m_a);
    endtask

    task automatic test_reset_mid_dump;
        logic [4:0] m_new;
        fill_random;
        m_in = 5'($urandom);
        ready = 1'b1;
        pulse_start;
        for (int i = 0; i < 10; i++) dump_word(i, 1'b1);
        ready = 1'b0;
        wait_valid("rst10");
        n_checks++;
        if (idx !== 5'd10) begin
            n_fail++;
            $display("FAIL rst_pre_idx: got %0d required 10", idx);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, busy, done, idx, bus.M_out, bus.out_data} !==
            {3'b000, 5'd0, 5'd0, BLANK_OUT}) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b busy=%b done=%b idx=%0d m=%b data=%h",
                     bus.out_valid, busy, done, idx, bus.M_out, bus.out_data);
        end
        tick;
        rst_n = 1'b1;
        fill_random;
        m_new = 5'($urandom);
        m_in = m_new;
        ready = 1'b1;
        pulse_start;
        for (int i = 0; i <= 16; i++) dump_word(i, 1'b1);
        check_done("redump", m_new);
    endtask

    initial begin
        test_reset;
        test_manual_dump;
        test_backpressure;
        test_auto_mode;
        test_ignored_inputs;
        test_reset_mid_dump;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
